// File: rtl/multicycle_controller.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC(/MEM), registered Z/C flags, return-stack pointer.
// Latency 3 cycles (ALU/branch/jump), 4+wait for LDM/STM; MEM stalls until mem_ack.
module multicycle_controller #(
    parameter int INSTR_W     = 19,
    parameter int STACK_DEPTH = 8,
    parameter int SP_W        = $clog2(STACK_DEPTH) + 1
) (
    input  logic               clock,
    input  logic               init_signal,
    input  logic [INSTR_W-1:0] instr,
    input  logic               zero_in,
    input  logic               carry_in,
    input  logic               mem_ack,
    output logic               ir_load,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               pc_adder_b_sel,
    output logic [3:0]         alu_fn,
    output logic               alu_b_sel,
    output logic               r2_sel,
    output logic               wb_sel,
    output logic               reg_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               push,
    output logic               pop,
    output logic               flag_z,
    output logic               flag_c,
    output logic [SP_W-1:0]    stack_ptr,
    output logic               stack_err,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3
    } state_t;

    localparam logic [SP_W-1:0] LP_FULL = SP_W'(STACK_DEPTH);
    localparam logic [SP_W-1:0] LP_ONE  = SP_W'(1);

    state_t          r_state;
    state_t          w_next;
    logic            r_run;
    logic            r_flag_z;
    logic            r_flag_c;
    logic            r_stack_err;
    logic [SP_W-1:0] r_sp;

    logic [5:0] w_op;
    logic       w_is_alu, w_is_shift, w_is_ldm, w_is_stm, w_is_br;
    logic       w_is_jmp, w_is_jsr, w_is_ret;
    logic       w_br_taken, w_push_ok, w_pop_ok, w_sel_en;
    logic       w_upd_z, w_upd_c, w_fault;
    logic       w_unused_bits;

    assign w_op          = instr[INSTR_W-1 -: 6];
    assign w_unused_bits = |instr[INSTR_W-7:0];

    assign w_is_alu   = (w_op[5] == 1'b0);
    assign w_is_shift = (w_op[5:3] == 3'b110);
    assign w_is_ldm   = (w_op[5:1] == 5'b10000);
    assign w_is_stm   = (w_op[5:1] == 5'b10001);
    assign w_is_br    = (w_op[5:3] == 3'b101);
    assign w_is_jmp   = (w_op[5:1] == 5'b11100);
    assign w_is_jsr   = (w_op[5:1] == 5'b11101);
    assign w_is_ret   = (w_op == 6'b111100);

    always_comb begin
        w_br_taken = 1'b0;
        case (w_op[2:1])
            2'b00: w_br_taken = r_flag_z;
            2'b01: w_br_taken = ~r_flag_z;
            2'b10: w_br_taken = r_flag_c;
            2'b11: w_br_taken = ~r_flag_c;
            default: w_br_taken = 1'b0;
        endcase
    end

    // Stack over/underflow turns JSR/RET into a NOP rather than corrupting the pointer.
    assign w_push_ok = w_is_jsr && (r_sp != LP_FULL);
    assign w_pop_ok  = w_is_ret && (r_sp != '0);
    assign w_sel_en  = (r_state == S_EXEC) || (r_state == S_MEM);

    always_comb begin
        w_next         = r_state;
        ir_load        = 1'b0;
        pc_write       = 1'b0;
        reg_write      = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        push           = 1'b0;
        pop            = 1'b0;
        w_upd_z        = 1'b0;
        w_upd_c        = 1'b0;
        w_fault        = 1'b0;
        alu_fn         = 4'b0000;
        alu_b_sel      = 1'b1;
        r2_sel         = 1'b1;
        wb_sel         = 1'b1;
        pc_src         = 2'b00;
        pc_adder_b_sel = 1'b1;

        if (w_sel_en) begin
            if (w_is_alu) begin
                alu_fn    = {1'b1, w_op[3:1]};
                alu_b_sel = ~w_op[4];
            end else if (w_is_shift) begin
                alu_fn = {2'b00, w_op[2:1]};
            end
            if (w_is_stm)                pc_src = pc_src;
            if (w_is_stm)                r2_sel = 1'b0;
            if (w_is_ldm)                wb_sel = 1'b0;
            if (w_is_jmp)                pc_src = 2'b01;
            if (w_pop_ok)                pc_src = 2'b10;
            if (w_is_br && w_br_taken)   pc_adder_b_sel = 1'b0;
        end

        case (r_state)
            S_FETCH: begin
                // r_run keeps the first post-reset cycle idle so ir_load only rises after release.
                if (r_run) begin
                    ir_load = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                if (w_is_ldm || w_is_stm) begin
                    w_next = S_MEM;
                end else begin
                    pc_write  = 1'b1;
                    reg_write = w_is_alu || w_is_shift;
                    push      = w_push_ok;
                    pop       = w_pop_ok;
                    w_upd_z   = w_is_alu;
                    w_upd_c   = w_is_alu || w_is_shift;
                    w_fault   = (w_is_jsr && !w_push_ok) || (w_is_ret && !w_pop_ok);
                    w_next    = S_FETCH;
                end
            end
            S_MEM: begin
                mem_read  = w_is_ldm;
                mem_write = w_is_stm;
                if (mem_ack) begin
                    mem_read  = 1'b0;
                    mem_write = 1'b0;
                    mem_read  = w_is_ldm;
                    mem_write = w_is_stm;
                    pc_write  = 1'b1;
                    reg_write = w_is_ldm;
                    w_next    = S_FETCH;
                end
            end
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!init_signal) begin
            r_state     <= S_FETCH;
            r_run       <= 1'b0;
            r_flag_z    <= 1'b0;
            r_flag_c    <= 1'b0;
            r_sp        <= '0;
            r_stack_err <= 1'b0;
        end else begin
            r_state <= w_next;
            r_run   <= 1'b1;
            if (w_upd_z) r_flag_z <= zero_in;
            if (w_upd_c) r_flag_c <= carry_in;
            if (push)
                r_sp <= r_sp + LP_ONE;
            else if (pop)
                r_sp <= r_sp - LP_ONE;
            if (w_fault) r_stack_err <= 1'b1;
        end
    end

    assign flag_z    = r_flag_z;
    assign flag_c    = r_flag_c;
    assign stack_ptr = r_sp;
    assign stack_err = r_stack_err;
    assign state     = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (STACK_DEPTH=2): sequencing, flags, stack limits, reset mid-MEM.
module tb_multicycle_controller;

    localparam int INSTR_W = 19;
    localparam int DEPTH   = 2;
    localparam int SP_W    = $clog2(DEPTH) + 1;

    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_LDM = 6'b100000;
    localparam logic [5:0] OP_STM = 6'b100010;
    localparam logic [5:0] OP_BZ  = 6'b101000;
    localparam logic [5:0] OP_BNZ = 6'b101010;
    localparam logic [5:0] OP_BC  = 6'b101100;
    localparam logic [5:0] OP_SHF = 6'b110010;
    localparam logic [5:0] OP_JMP = 6'b111000;
    localparam logic [5:0] OP_JSR = 6'b111010;
    localparam logic [5:0] OP_RET = 6'b111100;

    logic               clock = 1'b0;
    logic               init_signal;
    logic [INSTR_W-1:0] instr;
    logic               zero_in, carry_in, mem_ack;
    logic               ir_load, pc_write, pc_adder_b_sel, alu_b_sel, r2_sel, wb_sel;
    logic [1:0]         pc_src;
    logic [3:0]         alu_fn;
    logic               reg_write, mem_read, mem_write, push, pop;
    logic               flag_z, flag_c, stack_err;
    logic [SP_W-1:0]    stack_ptr;
    logic [2:0]         state;

    int n_checks = 0;
    int n_errors = 0;

    multicycle_controller #(.INSTR_W(INSTR_W), .STACK_DEPTH(DEPTH)) dut (
        .clock(clock), .init_signal(init_signal), .instr(instr),
        .zero_in(zero_in), .carry_in(carry_in), .mem_ack(mem_ack),
        .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src),
        .pc_adder_b_sel(pc_adder_b_sel), .alu_fn(alu_fn), .alu_b_sel(alu_b_sel),
        .r2_sel(r2_sel), .wb_sel(wb_sel), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .push(push), .pop(pop),
        .flag_z(flag_z), .flag_c(flag_c), .stack_ptr(stack_ptr),
        .stack_err(stack_err), .state(state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clock);
        #1;
    endtask

    // From a sampled FETCH cycle, present op and advance to its EXEC cycle.
    task automatic to_exec(input logic [5:0] op);
        instr = {op, 13'h0};
        cyc;
        cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        init_signal = 1'b0; instr = '0; zero_in = 1'b0; carry_in = 1'b0; mem_ack = 1'b0;
        cyc; cyc;
        chk("rst_state", state, 0);
        chk("rst_ir_load", ir_load, 0);
        chk("rst_sp", stack_ptr, 0);
        chk("rst_flags", {flag_z, flag_c, stack_err}, 0);
        chk("rst_sel", {alu_fn, alu_b_sel, r2_sel, wb_sel, pc_src, pc_adder_b_sel}, 10'b0000_1_1_1_00_1);

        // ADD with zero_in=1; mem_ack pulses in FETCH and EXEC must be ignored
        init_signal = 1'b1;
        cyc;
        chk("add_c1_ir_load", ir_load, 1);
        instr = {OP_ADD, 13'h0}; zero_in = 1'b1; carry_in = 1'b0; mem_ack = 1'b1;
        cyc;
        chk("add_c2", {state, ir_load, reg_write, pc_write}, {3'd1, 3'b000});
        mem_ack = 1'b0;
        cyc;
        mem_ack = 1'b1;
        chk("add_c3", {state, reg_write, pc_write, mem_read}, {3'd2, 3'b110});
        chk("add_sel", {alu_fn, alu_b_sel, wb_sel}, 6'b1000_1_1);
        cyc;
        mem_ack = 1'b0;
        chk("add_back_fetch", {state, ir_load}, {3'd0, 1'b1});
        chk("add_flags", {flag_z, flag_c}, 2'b10);

        // LDM, ack in 3rd MEM cycle: 6 cycles total
        zero_in = 1'b0;
        to_exec(OP_LDM);
        chk("ldm_exec", {state, mem_read, pc_write, reg_write, wb_sel}, {3'd2, 4'b0000});
        for (int i = 0; i < 3; i++) begin
            cyc;
            mem_ack = (i == 2);
            #1;
            chk("ldm_mem_read", mem_read, 1);
            chk("ldm_reg_write", {reg_write, pc_write, wb_sel}, (i == 2) ? 3'b110 : 3'b000);
        end
        cyc;
        mem_ack = 1'b0;
        chk("ldm_done", {state, mem_read, flag_z}, {3'd0, 1'b0, 1'b1});

        // Branches on registered flags, shift between them
        to_exec(OP_BZ);
        chk("bz_taken", {pc_adder_b_sel, pc_write}, 2'b01);
        cyc;
        zero_in = 1'b0; carry_in = 1'b1;
        to_exec(OP_SHF);
        chk("shf_exec", {alu_fn, reg_write}, 5'b0001_1);
        cyc;
        chk("shf_flags", {flag_z, flag_c}, 2'b11);
        to_exec(OP_BNZ);
        chk("bnz_not_taken", pc_adder_b_sel, 1);
        cyc;
        to_exec(OP_BC);
        chk("bc_taken", pc_adder_b_sel, 0);
        cyc;
        to_exec(OP_JMP);
        chk("jmp_src", {pc_src, pc_write}, 3'b01_1);
        cyc;

        // JSR x3 then RET x3 at depth 2
        for (int i = 0; i < 3; i++) begin
            to_exec(OP_JSR);
            chk("jsr_push", push, (i < 2) ? 1 : 0);
            chk("jsr_src", {pc_src, pc_adder_b_sel}, 3'b00_1);
            cyc;
            chk("jsr_sp", stack_ptr, (i == 0) ? 1 : 2);
        end
        chk("jsr_err", stack_err, 1);
        for (int i = 0; i < 3; i++) begin
            to_exec(OP_RET);
            chk("ret_pop", {pop, pc_src}, (i < 2) ? 3'b1_10 : 3'b0_00);
            cyc;
            chk("ret_sp", stack_ptr, (i == 0) ? 1 : 0);
        end
        chk("ret_err", stack_err, 1);

        // Reset while STM waits in MEM
        to_exec(OP_JSR);
        cyc;
        chk("pre_rst_sp", stack_ptr, 1);
        to_exec(OP_STM);
        cyc;
        chk("stm_mem", {state, mem_write, r2_sel}, {3'd3, 2'b10});
        init_signal = 1'b0;
        cyc;
        chk("mid_rst", {state, mem_write, ir_load}, {3'd0, 2'b00});
        chk("mid_rst_regs", {stack_ptr, stack_err, flag_z, flag_c}, 0);
        cyc;
        chk("hold_rst", {state, ir_load}, 0);
        init_signal = 1'b1;
        cyc;
        chk("release_ir_load", {state, ir_load}, {3'd0, 1'b1});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
